// File: rtl/ram_bus_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ram_bus_arbiter_if
// Purpose  : Groups the two requester ports (CPU, DMA) and the RAM port of
//            the shared data-RAM arbiter.
// Modports : slave  - arbiter view. It takes requests and RAM read data in,
//                     and drives grants, acks, read data and the RAM strobes.
//            master - environment view. Requesters and RAM drive the
//                     arbiter's inputs and observe its outputs.
// Ports    : CPU_* / DMA_*  Req, Write, Addr, WData in; Gnt, Ack, RData out
//            RAM_*          Cs, WE, Addr, WData out; RData in
// Revision : 1.0 - initial release
// ============================================================================
interface ram_bus_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              CPU_Req;
  logic              CPU_Write;
  logic [ADDR_W-1:0] CPU_Addr;
  logic [DATA_W-1:0] CPU_WData;
  logic              CPU_Gnt;
  logic              CPU_Ack;
  logic [DATA_W-1:0] CPU_RData;

  logic              DMA_Req;
  logic              DMA_Write;
  logic [ADDR_W-1:0] DMA_Addr;
  logic [DATA_W-1:0] DMA_WData;
  logic              DMA_Gnt;
  logic              DMA_Ack;
  logic [DATA_W-1:0] DMA_RData;

  logic              RAM_Cs;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_Addr;
  logic [DATA_W-1:0] RAM_WData;
  logic [DATA_W-1:0] RAM_RData;

  modport slave (
    input  CPU_Req, CPU_Write, CPU_Addr, CPU_WData,
    input  DMA_Req, DMA_Write, DMA_Addr, DMA_WData,
    input  RAM_RData,
    output CPU_Gnt, CPU_Ack, CPU_RData,
    output DMA_Gnt, DMA_Ack, DMA_RData,
    output RAM_Cs, RAM_WE, RAM_Addr, RAM_WData
  );

  modport master (
    output CPU_Req, CPU_Write, CPU_Addr, CPU_WData,
    output DMA_Req, DMA_Write, DMA_Addr, DMA_WData,
    output RAM_RData,
    input  CPU_Gnt, CPU_Ack, CPU_RData,
    input  DMA_Gnt, DMA_Ack, DMA_RData,
    input  RAM_Cs, RAM_WE, RAM_Addr, RAM_WData
  );
endinterface
`default_nettype wire

// File: rtl/ram_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ram_bus_arbiter
// Purpose  : Shares a single-port synchronous data RAM between the CPU and
//            the DMA engine. The arbiter grants one transaction at a time in
//            the sequence IDLE -> ACCESS -> RESP. The CPU has fixed priority.
//            A starvation counter forces a DMA win after STARVE_LIM contended
//            losses.
// Ports    : Clk    - system clock, rising edge
//            Rst_n  - synchronous active-low reset
//            bus    - ram_bus_arbiter_if.slave (requesters + RAM port)
// Revision : 1.0 - initial release
// ============================================================================
module ram_bus_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int STARVE_LIM = 3
) (
  input  wire logic            Clk,
  input  wire logic            Rst_n,
  ram_bus_arbiter_if.slave     bus
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] C_LIM = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state;
  logic             owner_dma;
  logic [CNT_W-1:0] starve_cnt;

  // Winner of the current IDLE arbitration. DMA wins when it is the only
  // requester, or when it has already lost STARVE_LIM contended rounds.
  logic              pick_dma;
  logic              both_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;

  assign both_req  = bus.CPU_Req && bus.DMA_Req;
  assign pick_dma  = bus.DMA_Req && (!bus.CPU_Req || (starve_cnt == C_LIM));
  assign sel_addr  = pick_dma ? bus.DMA_Addr  : bus.CPU_Addr;
  assign sel_wdata = pick_dma ? bus.DMA_WData : bus.CPU_WData;
  assign sel_write = pick_dma ? bus.DMA_Write : bus.CPU_Write;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state         <= IDLE;
      owner_dma     <= 1'b0;
      starve_cnt    <= '0;
      bus.CPU_Gnt   <= 1'b0;
      bus.DMA_Gnt   <= 1'b0;
      bus.CPU_Ack   <= 1'b0;
      bus.DMA_Ack   <= 1'b0;
      bus.RAM_Cs    <= 1'b0;
      bus.RAM_WE    <= 1'b0;
      bus.RAM_Addr  <= '0;
      bus.RAM_WData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.CPU_Req || bus.DMA_Req) begin
            state         <= ACCESS;
            owner_dma     <= pick_dma;
            bus.CPU_Gnt   <= !pick_dma;
            bus.DMA_Gnt   <= pick_dma;
            bus.RAM_Cs    <= 1'b1;
            bus.RAM_WE    <= sel_write;
            bus.RAM_Addr  <= sel_addr;
            bus.RAM_WData <= sel_wdata;
            // A DMA grant clears the count. A contended CPU win adds one,
            // saturating at the limit.
            if (pick_dma) begin
              starve_cnt <= '0;
            end else if (both_req && (starve_cnt != C_LIM)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        ACCESS: begin
          // Address and data keep their last values. Only the strobes drop.
          state       <= RESP;
          bus.RAM_Cs  <= 1'b0;
          bus.RAM_WE  <= 1'b0;
          bus.CPU_Ack <= !owner_dma;
          bus.DMA_Ack <= owner_dma;
        end
        RESP: begin
          state       <= IDLE;
          bus.CPU_Gnt <= 1'b0;
          bus.DMA_Gnt <= 1'b0;
          bus.CPU_Ack <= 1'b0;
          bus.DMA_Ack <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Synchronous RAM data arrives during RESP. That is exactly when the
  // owner's Ack is high, so the Ack gates the read data to the owner only.
  assign bus.CPU_RData = bus.CPU_Ack ? bus.RAM_RData : '0;
  assign bus.DMA_RData = bus.DMA_Ack ? bus.RAM_RData : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ram_bus_arbiter
// Purpose  : Self-checking bench for ram_bus_arbiter. A transaction-level
//            model predicts each grant, its RAM strobe cycle and its Ack.
//            An independent monitor compares the DUT against that queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bus_arbiter;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int STARVE_LIM = 3;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  ram_bus_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_bus_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus.slave)
  );

  // Requester state, index 0 = CPU, 1 = DMA
  bit         req  [2];
  bit         wr   [2];
  logic [7:0] ad   [2];
  logic [7:0] wd   [2];
  bit         pend [2];

  assign bus.CPU_Req   = req[0];
  assign bus.CPU_Write = wr[0];
  assign bus.CPU_Addr  = ad[0];
  assign bus.CPU_WData = wd[0];
  assign bus.DMA_Req   = req[1];
  assign bus.DMA_Write = wr[1];
  assign bus.DMA_Addr  = ad[1];
  assign bus.DMA_WData = wd[1];

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h63;
  endfunction

  // Synchronous RAM. Unwritten locations read init_val(addr).
  logic [7:0] ram     [256];
  bit         written [256];
  always @(posedge Clk) begin
    if (bus.RAM_Cs) begin
      if (bus.RAM_WE) begin
        ram[bus.RAM_Addr]     <= bus.RAM_WData;
        written[bus.RAM_Addr] <= 1'b1;
      end
      bus.RAM_RData <= written[bus.RAM_Addr] ? ram[bus.RAM_Addr] : init_val(bus.RAM_Addr);
    end
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Transaction-level model
  typedef struct {
    bit         dma;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         cs_cyc;
  } exp_t;

  exp_t       cs_q  [$];
  exp_t       ack_q [$];
  bit         dut_log [$];
  logic [7:0] mmem [256];
  int         next_arb = 0;
  int         starve   = 0;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Present requests for the next rising edge. If that edge is an
  // arbitration point, predict the outcome. Return #1 after the edge.
  task automatic tick(input bit r0, input bit r1);
    exp_t e;
    int   m;
    bit   dma;
    req[0] = r0;
    req[1] = r1;
    if (cyc + 1 == next_arb) begin
      if (r0 || r1) begin
        dma = r1 && (!r0 || starve == STARVE_LIM);
        if (dma) starve = 0;
        else if (r1 && starve < STARVE_LIM) starve++;
        m        = dma ? 1 : 0;
        e.dma    = dma;
        e.wr     = wr[m];
        e.addr   = ad[m];
        e.wdata  = wd[m];
        e.rdata  = mmem[ad[m]];
        e.cs_cyc = cyc + 1;
        if (wr[m]) mmem[ad[m]] = wd[m];
        cs_q.push_back(e);
        ack_q.push_back(e);
        pend[m]  = 1'b0;
        next_arb = cyc + 4;
      end else begin
        next_arb = cyc + 2;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic set_txn(input int m, input bit w, input logic [7:0] a, input logic [7:0] d);
    wr[m] = w; ad[m] = a; wd[m] = d; pend[m] = 1'b1;
  endtask

  task automatic rand_txn(input int m);
    if (!pend[m]) set_txn(m, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
  endtask

  // Random request noise between arbitration points must be ignored by the DUT.
  task automatic to_arb();
    while (cyc + 1 != next_arb) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    repeat (6) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    cs_q.delete();
    ack_q.delete();
    req[0] = 1'b0; req[1] = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst_n    = 1'b1;
    starve   = 0;
    pend[0]  = 1'b0;
    pend[1]  = 1'b0;
    next_arb = cyc + 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_gnt"},   bus.CPU_Gnt,   0);
    chk({tag, "_dma_gnt"},   bus.DMA_Gnt,   0);
    chk({tag, "_cpu_ack"},   bus.CPU_Ack,   0);
    chk({tag, "_dma_ack"},   bus.DMA_Ack,   0);
    chk({tag, "_ram_cs"},    bus.RAM_Cs,    0);
    chk({tag, "_ram_we"},    bus.RAM_WE,    0);
    chk({tag, "_ram_addr"},  bus.RAM_Addr,  0);
    chk({tag, "_ram_wdata"}, bus.RAM_WData, 0);
    chk({tag, "_cpu_rdata"}, bus.CPU_RData, 0);
    chk({tag, "_dma_rdata"}, bus.DMA_RData, 0);
  endtask

  // Monitor: compares DUT activity against the predicted queues.
  exp_t me;
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (cs_q.size() > 0 && cs_q[0].cs_cyc < cyc) begin
        chk("ram_cs_missing", 0, 1);
        void'(cs_q.pop_front());
      end
      if (bus.RAM_Cs) begin
        if (cs_q.size() == 0 || cs_q[0].cs_cyc != cyc) begin
          chk("ram_cs_unexpected", 1, 0);
        end else begin
          me = cs_q.pop_front();
          chk("ram_we",   bus.RAM_WE,   me.wr);
          chk("ram_addr", bus.RAM_Addr, me.addr);
          if (me.wr) chk("ram_wdata", bus.RAM_WData, me.wdata);
          chk("access_gnt", {bus.CPU_Gnt, bus.DMA_Gnt}, me.dma ? 2'b01 : 2'b10);
          chk("access_ack", {bus.CPU_Ack, bus.DMA_Ack}, 2'b00);
        end
      end
      if (ack_q.size() > 0 && ack_q[0].cs_cyc + 1 < cyc) begin
        chk("ack_missing", 0, 1);
        void'(ack_q.pop_front());
      end
      if (bus.CPU_Ack || bus.DMA_Ack) begin
        if (ack_q.size() == 0 || ack_q[0].cs_cyc + 1 != cyc) begin
          chk("ack_unexpected", {bus.CPU_Ack, bus.DMA_Ack}, 2'b00);
        end else begin
          me = ack_q.pop_front();
          dut_log.push_back(bus.DMA_Ack);
          chk("ack_owner", {bus.CPU_Ack, bus.DMA_Ack}, me.dma ? 2'b01 : 2'b10);
          chk("resp_gnt",  {bus.CPU_Gnt, bus.DMA_Gnt}, me.dma ? 2'b01 : 2'b10);
          chk("resp_cs",   bus.RAM_Cs, 0);
          if (me.dma) begin
            chk("cpu_rdata_idle", bus.CPU_RData, 0);
            if (!me.wr) chk("dma_rdata", bus.DMA_RData, me.rdata);
          end else begin
            chk("dma_rdata_idle", bus.DMA_RData, 0);
            if (!me.wr) chk("cpu_rdata", bus.CPU_RData, me.rdata);
          end
        end
      end
    end
  end

  initial begin
    bit exp_order [];
    for (int i = 0; i < 256; i++) mmem[i] = init_val(8'(i));
    for (int m = 0; m < 2; m++) begin
      req[m] = 0; wr[m] = 0; ad[m] = 0; wd[m] = 0; pend[m] = 0;
    end

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk_all_zero("reset");
    Rst_n    = 1'b1;
    next_arb = cyc + 1;

    // CPU write A5 @10, then read it back
    set_txn(0, 1'b1, 8'h10, 8'hA5);
    to_arb(); tick(1'b1, 1'b0);
    set_txn(0, 1'b0, 8'h10, 8'h00);
    to_arb(); tick(1'b1, 1'b0);
    drain();

    // DMA-only read @3F, which holds 5C from initial content
    set_txn(1, 1'b0, 8'h3F, 8'h00);
    to_arb(); tick(1'b0, 1'b1);
    drain();

    // Continuous contention: CPU,CPU,CPU,DMA,CPU,CPU,CPU,DMA
    do_reset();
    dut_log.delete();
    for (int i = 0; i < 8; i++) begin
      rand_txn(0); rand_txn(1);
      to_arb(); tick(1'b1, 1'b1);
    end
    drain();
    exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};
    chk("contend_count", dut_log.size(), 8);
    for (int i = 0; i < 8 && i < dut_log.size(); i++) chk("contend_order", dut_log[i], exp_order[i]);

    // Starve count at 2, DMA drops out. CPU wins and the count holds at 2.
    do_reset();
    dut_log.delete();
    for (int i = 0; i < 5; i++) begin
      rand_txn(0); rand_txn(1);
      to_arb();
      if (i == 2) tick(1'b1, 1'b0);
      else        tick(1'b1, 1'b1);
    end
    drain();
    exp_order = '{0, 0, 0, 0, 1};
    chk("drop_count", dut_log.size(), 5);
    for (int i = 0; i < 5 && i < dut_log.size(); i++) chk("drop_order", dut_log[i], exp_order[i]);

    // Reset in ACCESS of a DMA write: outputs clear and no Ack follows
    do_reset();
    set_txn(1, 1'b1, 8'h22, 8'h77);
    to_arb(); tick(1'b0, 1'b1);
    @(negedge Clk); #1;
    Rst_n = 1'b0;
    cs_q.delete();
    ack_q.delete();
    req[1] = 1'b0;
    @(posedge Clk); #1;
    chk_all_zero("midreset");
    Rst_n    = 1'b1;
    starve   = 0;
    pend[0]  = 1'b0;
    pend[1]  = 1'b0;
    next_arb = cyc + 1;
    dut_log.delete();
    rand_txn(0); rand_txn(1);
    to_arb(); tick(1'b1, 1'b1);
    drain();
    chk("post_reset_count", dut_log.size(), 1);
    if (dut_log.size() > 0) chk("post_reset_first_cpu", dut_log[0], 0);

    // CPU request pulsed for a single cycle still completes
    set_txn(0, 1'b0, 8'h22, 8'h00);
    to_arb(); tick(1'b1, 1'b0);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    set_txn(1, 1'b0, 8'h10, 8'h00);
    to_arb(); tick(1'b0, 1'b1);
    drain();

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      bit r0, r1;
      if ($urandom_range(0, 3) != 0) rand_txn(0);
      if ($urandom_range(0, 3) != 0) rand_txn(1);
      r0 = pend[0] && ($urandom_range(0, 7) != 0);
      r1 = pend[1] && ($urandom_range(0, 7) != 0);
      to_arb(); tick(r0, r1);
    end
    drain();
    chk("queue_empty", ack_q.size() + cs_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
